// File: rtl/cla_pipe_alu_adder_pkg.sv
// Shared types and sizing helpers for the pipelined carry-lookahead adder.
// Segment geometry depends on the instance parameters, so it is exposed as functions.
package adder_pkg;

    typedef enum logic [1:0] {
        ADD    = 2'd0,
        SUB    = 2'd1,
        SATADD = 2'd2,
        PADDSB = 2'd3
    } add_op_t;

    localparam int unsigned GROUP_W    = 4;
    localparam int unsigned DEF_WIDTH  = 16;
    localparam int unsigned DEF_STAGES = 2;

    function automatic int unsigned ngroups(input int unsigned width);
        return width / GROUP_W;
    endfunction

    function automatic int unsigned gps(input int unsigned width, input int unsigned stages);
        return ngroups(width) / stages;
    endfunction

endpackage

// File: rtl/cla_pipe_alu_adder_cla4_pg.sv
// 4-bit carry-lookahead slice: local sum plus group propagate/generate.
// kill_i forces the slice carry-in to zero so packed lanes stay independent.
module cla4_pg (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    input  logic       kill_i,
    output logic [3:0] sum_o,
    output logic       p_o,
    output logic       g_o
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    // P/G depend only on the operands, keeping them off the carry-in path.
    assign p   = a_i ^ b_i;
    assign g   = a_i & b_i;
    assign p_o = &p;
    assign g_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

    always_comb begin
        c     = '0;
        c[0]  = cin_i & ~kill_i;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        sum_o = p ^ c;
    end

endmodule

// File: rtl/cla_pipe_alu_adder.sv
// Pipelined CLA add/sub datapath with saturation, packed nibble add and N/Z/V/C flags.
// Each stage resolves one segment of groups; the last stage also saturates and flags.
module cla_pipe_alu_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  add_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_c
);

    localparam int unsigned NG    = ngroups(WIDTH);
    localparam int unsigned GPS   = gps(WIDTH, STAGES);
    localparam int unsigned SEG_W = GPS * GROUP_W;

    typedef struct packed {
        logic             valid;
        add_op_t          op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] psum;
        logic             carry;
    } stage_t;

    stage_t                in_stage;
    stage_t [STAGES-1:0]   seg_out_w;
    stage_t                fin;
    logic                  advance;

    logic                  out_valid_q;
    logic [WIDTH-1:0]      sum_q, sum_d;
    logic                  n_q, z_q, v_q, c_q;
    logic                  n_d, z_d, v_d, c_d;
    logic                  ovf;

    assign advance  = ~out_valid_q | out_ready;
    assign in_ready = advance;

    // b is stored already inverted for SUB so later stages and flags see the effective operand.
    always_comb begin
        in_stage       = '0;
        in_stage.valid = in_valid;
        in_stage.op    = op;
        in_stage.a     = a;
        in_stage.b     = (op == SUB) ? ~b : b;
        in_stage.carry = (op == ADD) ? cin : (op == SUB);
        in_stage.psum  = '0;
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_seg
        stage_t           seg_in;
        stage_t           seg_out;
        logic [GPS-1:0]   gp;
        logic [GPS-1:0]   gg;
        logic [GPS:0]     gc;
        logic [SEG_W-1:0] gsum;
        logic             kill;

        if (s == 0) begin : g_first
            assign seg_in = in_stage;
        end else begin : g_reg
            stage_t stage_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage_q <= '0;
                end else if (flush) begin
                    stage_q.valid <= 1'b0;
                end else if (advance) begin
                    stage_q <= seg_out_w[s-1];
                end
            end
            assign seg_in = stage_q;
        end

        assign kill = (seg_in.op == PADDSB);

        for (genvar j = 0; j < GPS; j++) begin : g_grp
            cla4_pg u_cla4 (
                .a_i    (seg_in.a[s*SEG_W + j*GROUP_W +: GROUP_W]),
                .b_i    (seg_in.b[s*SEG_W + j*GROUP_W +: GROUP_W]),
                .cin_i  (gc[j]),
                .kill_i (kill),
                .sum_o  (gsum[j*GROUP_W +: GROUP_W]),
                .p_o    (gp[j]),
                .g_o    (gg[j])
            );
        end

        // Flattened sum-of-products per group carry: second lookahead level over group P/G.
        always_comb begin
            logic term;
            logic prod;
            term  = 1'b0;
            prod  = 1'b0;
            gc    = '0;
            gc[0] = seg_in.carry;
            for (int unsigned j = 0; j < GPS; j++) begin
                term = gg[j];
                prod = gp[j];
                for (int unsigned k = 1; k <= j; k++) begin
                    term = term | (prod & gg[j-k]);
                    prod = prod & gp[j-k];
                end
                gc[j+1] = term | (prod & seg_in.carry);
            end
        end

        always_comb begin
            seg_out                        = seg_in;
            seg_out.psum[s*SEG_W +: SEG_W] = gsum;
            seg_out.carry                  = gc[GPS];
        end

        assign seg_out_w[s] = seg_out;
    end

    assign fin = seg_out_w[STAGES-1];

    always_comb begin
        sum_d = fin.psum;
        v_d   = 1'b0;
        c_d   = fin.carry;
        ovf   = (fin.a[WIDTH-1] == fin.b[WIDTH-1]) && (fin.psum[WIDTH-1] != fin.a[WIDTH-1]);
        case (fin.op)
            SATADD: begin
                v_d = ovf;
                if (ovf) begin
                    sum_d = fin.a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
            PADDSB: begin
                c_d = 1'b0;
                for (int unsigned l = 0; l < NG; l++) begin
                    if ((fin.a[l*GROUP_W + GROUP_W-1] == fin.b[l*GROUP_W + GROUP_W-1]) &&
                        (fin.psum[l*GROUP_W + GROUP_W-1] != fin.a[l*GROUP_W + GROUP_W-1])) begin
                        sum_d[l*GROUP_W +: GROUP_W] = fin.a[l*GROUP_W + GROUP_W-1] ? 4'h8 : 4'h7;
                        v_d = 1'b1;
                    end
                end
            end
            default: v_d = ovf;
        endcase
        n_d = sum_d[WIDTH-1];
        z_d = (sum_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            v_q         <= 1'b0;
            c_q         <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (advance) begin
            out_valid_q <= fin.valid;
            sum_q       <= sum_d;
            n_q         <= n_d;
            z_q         <= z_d;
            v_q         <= v_d;
            c_q         <= c_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign flag_n    = n_q;
    assign flag_z    = z_q;
    assign flag_v    = v_q;
    assign flag_c    = c_q;

endmodule
